// File: rtl/vram_write_arbiter.sv
// vram_write_arbiter: owns VRAM write port A, sharing it between buffered
// CPU pixel writes and a rectangle-fill engine, one write per clock.
// Ports:
//   clk, RSTN (async active-low)
//   cpu_we/cpu_addr/cpu_data  -> CPU write strobe into a FIFO
//   cpu_full, cpu_ovf         <- FIFO full, sticky dropped-write flag
//   fill_start, fill_x/y/w/h, fill_color -> rectangle fill request
//   fill_abort (only with VRAM_FILL_ABORT_EN) -> stop a running fill
//   fill_busy, fill_done, fill_err <- fill engine status
//   vram_we/vram_addr/vram_data    <- registered VRAM port A write
// Optional feature macro: VRAM_FILL_ABORT_EN.
module vram_write_arbiter #(
  parameter int ADDR_W     = 13,
  parameter int DATA_W     = 12,
  parameter int COLS       = 80,
  parameter int ROWS       = 60,
  parameter int FIFO_DEPTH = 4
) (
  input  logic              clk,
  input  logic              RSTN,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_data,
  output logic              cpu_full,
  output logic              cpu_ovf,
  input  logic              fill_start,
  input  logic [6:0]        fill_x,
  input  logic [5:0]        fill_y,
  input  logic [6:0]        fill_w,
  input  logic [5:0]        fill_h,
  input  logic [DATA_W-1:0] fill_color,
`ifdef VRAM_FILL_ABORT_EN
  input  logic              fill_abort,
`endif
  output logic              fill_busy,
  output logic              fill_done,
  output logic              fill_err,
  output logic              vram_we,
  output logic [ADDR_W-1:0] vram_addr,
  output logic [DATA_W-1:0] vram_data
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;
  localparam logic [7:0] COLS8 = 8'(COLS);
  localparam logic [6:0] ROWS7 = 7'(ROWS);

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } wr_t;

  typedef enum logic [1:0] {
    S_IDLE,
    S_SETUP,
    S_RUN,
    S_DONE
  } state_e;

  // y*COLS as a shift-add over the set bits of COLS
  function automatic logic [ADDR_W-1:0] row_base(
    input logic [5:0] y
  );
    logic [ADDR_W-1:0] acc;
    acc = '0;
    for (int i = 0; i < 31; i++) begin
      if (((COLS >> i) & 1) != 0) begin
        acc = acc + (ADDR_W'(y) << i);
      end
    end
    return acc;
  endfunction

  logic abort;
`ifdef VRAM_FILL_ABORT_EN
  assign abort = fill_abort;
`else
  assign abort = 1'b0;
`endif

  // ---------------- CPU FIFO ----------------
  wr_t           mem_q [FIFO_DEPTH];
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          cpu_ovf_q, cpu_ovf_d;

  logic fifo_empty;
  logic push;
  logic mem_we;
  logic pop_mem;
  logic cpu_req;
  wr_t  cpu_in;
  wr_t  head;

  assign fifo_empty = (cnt_q == '0);
  assign cpu_full   = (cnt_q == CW'(FIFO_DEPTH));
  assign push       = cpu_we & ~cpu_full;
  assign cpu_in     = '{addr: cpu_addr, data: cpu_data};

  // An empty FIFO passes the incoming write straight through,
  // giving single-cycle latency.
  assign cpu_req = ~fifo_empty | cpu_we;
  assign head    = fifo_empty ? cpu_in : mem_q[rd_ptr_q];

  // ---------------- fill engine ----------------
  state_e            state_q, state_d;
  logic [6:0]        x_q, x_d;
  logic [5:0]        y_q, y_d;
  logic [6:0]        w_q, w_d;
  logic [5:0]        h_q, h_d;
  logic [6:0]        col_q, col_d;
  logic [6:0]        col_last_q, col_last_d;
  logic [ADDR_W-1:0] base_q, base_d;
  logic [DATA_W-1:0] color_q, color_d;
  logic              clip_q, clip_d;
  logic              fill_err_q, fill_err_d;

  logic [7:0]        room_x;
  logic [6:0]        room_y;
  logic [6:0]        w_clip;
  logic [5:0]        h_clip;
  logic              reject;
  logic              clipped;
  logic              fill_req;
  logic [ADDR_W-1:0] fill_addr;

  assign room_x  = COLS8 - {1'b0, x_q};
  assign room_y  = ROWS7 - {1'b0, y_q};
  assign reject  = ({1'b0, x_q} >= COLS8) |
                   ({1'b0, y_q} >= ROWS7) |
                   (w_q == '0) | (h_q == '0);
  assign w_clip  = ({1'b0, w_q} > room_x) ? 7'(room_x) : w_q;
  assign h_clip  = ({1'b0, h_q} > room_y) ? 6'(room_y) : h_q;
  assign clipped = (w_clip != w_q) | (h_clip != h_q);

  assign fill_req  = (state_q == S_RUN) & ~abort;
  assign fill_addr = base_q + ADDR_W'(col_q);

  // ---------------- arbiter ----------------
  logic ptr_q, ptr_d;
  logic cpu_gnt;
  logic fill_gnt;

  // ptr_q: 0 favours CPU, 1 favours FILL; flips only on contention
  assign cpu_gnt  = cpu_req & (~fill_req | ~ptr_q);
  assign fill_gnt = fill_req & (~cpu_req | ptr_q);
  assign ptr_d    = (cpu_req & fill_req) ? ~ptr_q : ptr_q;

  assign pop_mem = cpu_gnt & ~fifo_empty;
  assign mem_we  = push & ~(fifo_empty & cpu_gnt);

  always_comb begin
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    cnt_d     = cnt_q;
    cpu_ovf_d = cpu_ovf_q | (cpu_we & cpu_full);
    if (mem_we) begin
      wr_ptr_d = wr_ptr_q + PW'(1);
    end
    if (pop_mem) begin
      rd_ptr_d = rd_ptr_q + PW'(1);
    end
    if (mem_we & ~pop_mem) begin
      cnt_d = cnt_q + CW'(1);
    end else if (~mem_we & pop_mem) begin
      cnt_d = cnt_q - CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem_q[wr_ptr_q] <= cpu_in;
    end
  end

  always_comb begin
    state_d    = state_q;
    x_d        = x_q;
    y_d        = y_q;
    w_d        = w_q;
    h_d        = h_q;
    col_d      = col_q;
    col_last_d = col_last_q;
    base_d     = base_q;
    color_d    = color_q;
    clip_d     = clip_q;
    fill_err_d = fill_err_q;
    unique case (state_q)
      S_IDLE: begin
        if (fill_start) begin
          x_d     = fill_x;
          y_d     = fill_y;
          w_d     = fill_w;
          h_d     = fill_h;
          color_d = fill_color;
          state_d = S_SETUP;
        end
      end
      S_SETUP: begin
        if (abort | reject) begin
          fill_err_d = 1'b1;
          state_d    = S_DONE;
        end else begin
          col_d      = x_q;
          col_last_d = x_q + w_clip - 7'd1;
          h_d        = h_clip;
          base_d     = row_base(y_q);
          clip_d     = clipped;
          state_d    = S_RUN;
        end
      end
      S_RUN: begin
        if (abort) begin
          fill_err_d = 1'b1;
          state_d    = S_DONE;
        end else if (fill_gnt) begin
          if (col_q == col_last_q) begin
            if (h_q == 6'd1) begin
              fill_err_d = clip_q;
              state_d    = S_DONE;
            end else begin
              h_d    = h_q - 6'd1;
              col_d  = x_q;
              base_d = base_q + ADDR_W'(COLS);
            end
          end else begin
            col_d = col_q + 7'd1;
          end
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // ---------------- output register ----------------
  logic              vram_we_q, vram_we_d;
  logic [ADDR_W-1:0] vram_addr_q, vram_addr_d;
  logic [DATA_W-1:0] vram_data_q, vram_data_d;

  always_comb begin
    vram_we_d   = cpu_gnt | fill_gnt;
    vram_addr_d = vram_addr_q;
    vram_data_d = vram_data_q;
    unique case (1'b1)
      cpu_gnt: begin
        vram_addr_d = head.addr;
        vram_data_d = head.data;
      end
      fill_gnt: begin
        vram_addr_d = fill_addr;
        vram_data_d = color_q;
      end
      default: begin
        vram_addr_d = vram_addr_q;
      end
    endcase
  end

  always_ff @(posedge clk or negedge RSTN) begin
    if (!RSTN) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      cnt_q       <= '0;
      cpu_ovf_q   <= 1'b0;
      ptr_q       <= 1'b0;
      state_q     <= S_IDLE;
      x_q         <= '0;
      y_q         <= '0;
      w_q         <= '0;
      h_q         <= '0;
      col_q       <= '0;
      col_last_q  <= '0;
      base_q      <= '0;
      color_q     <= '0;
      clip_q      <= 1'b0;
      fill_err_q  <= 1'b0;
      vram_we_q   <= 1'b0;
      vram_addr_q <= '0;
      vram_data_q <= '0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      cnt_q       <= cnt_d;
      cpu_ovf_q   <= cpu_ovf_d;
      ptr_q       <= ptr_d;
      state_q     <= state_d;
      x_q         <= x_d;
      y_q         <= y_d;
      w_q         <= w_d;
      h_q         <= h_d;
      col_q       <= col_d;
      col_last_q  <= col_last_d;
      base_q      <= base_d;
      color_q     <= color_d;
      clip_q      <= clip_d;
      fill_err_q  <= fill_err_d;
      vram_we_q   <= vram_we_d;
      vram_addr_q <= vram_addr_d;
      vram_data_q <= vram_data_d;
    end
  end

  assign cpu_ovf   = cpu_ovf_q;
  assign fill_busy = (state_q != S_IDLE);
  assign fill_done = (state_q == S_DONE);
  assign fill_err  = fill_err_q;
  assign vram_we   = vram_we_q;
  assign vram_addr = vram_addr_q;
  assign vram_data = vram_data_q;

endmodule

// File: tb/tb_vram_write_arbiter.sv
// tb_vram_write_arbiter: directed stimulus with a write scoreboard
// and a monitor that checks every VRAM write in order.
module tb_vram_write_arbiter;
  localparam int AW = 13;
  localparam int DW = 12;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          cpu_we = 1'b0;
  logic [AW-1:0] cpu_addr = '0;
  logic [DW-1:0] cpu_data = '0;
  logic          cpu_full, cpu_ovf;
  logic          fill_start = 1'b0;
  logic [6:0]    fill_x = '0;
  logic [5:0]    fill_y = '0;
  logic [6:0]    fill_w = '0;
  logic [5:0]    fill_h = '0;
  logic [DW-1:0] fill_color = '0;
  logic          fill_busy, fill_done, fill_err;
  logic          vram_we;
  logic [AW-1:0] vram_addr;
  logic [DW-1:0] vram_data;

  always #5 clk = ~clk;

  vram_write_arbiter dut (
    .clk(clk),
    .RSTN(rst_n),
    .cpu_we(cpu_we),
    .cpu_addr(cpu_addr),
    .cpu_data(cpu_data),
    .cpu_full(cpu_full),
    .cpu_ovf(cpu_ovf),
    .fill_start(fill_start),
    .fill_x(fill_x),
    .fill_y(fill_y),
    .fill_w(fill_w),
    .fill_h(fill_h),
    .fill_color(fill_color),
`ifdef VRAM_FILL_ABORT_EN
    .fill_abort(1'b0),
`endif
    .fill_busy(fill_busy),
    .fill_done(fill_done),
    .fill_err(fill_err),
    .vram_we(vram_we),
    .vram_addr(vram_addr),
    .vram_data(vram_data)
  );

  typedef struct packed {
    logic [AW-1:0] a;
    logic [DW-1:0] d;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   errors = 0;
  int   done_cnt = 0;
  bit   mon_en = 1'b1;

  task automatic chk(input string name,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, got, exp);
    end
  endtask

  task automatic expect_wr(input int a, input logic [DW-1:0] d);
    exp_t e;
    e.a = AW'(a);
    e.d = d;
    q.push_back(e);
  endtask

  // monitor: every VRAM write must match the scoreboard head
  always @(negedge clk) begin
    if (fill_done) done_cnt++;
    if (mon_en && rst_n && vram_we) begin
      if (q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_write: addr %0d data %03h, none expected",
                 vram_addr, vram_data);
      end else begin
        exp_t e;
        e = q.pop_front();
        chk("wr_addr", 32'(vram_addr), 32'(e.a));
        chk("wr_data", 32'(vram_data), 32'(e.d));
      end
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic start_fill(input logic [6:0] x, input logic [5:0] y,
                            input logic [6:0] w, input logic [5:0] h,
                            input logic [DW-1:0] c);
    fill_x     = x;
    fill_y     = y;
    fill_w     = w;
    fill_h     = h;
    fill_color = c;
    fill_start = 1'b1;
    cyc();
    fill_start = 1'b0;
  endtask

  task automatic wait_done(input string name, input int budget);
    int d0;
    int n;
    d0 = done_cnt;
    n  = 0;
    while (done_cnt == d0 && n < budget) begin
      cyc();
      n++;
    end
    chk(name, 32'(done_cnt != d0), 32'd1);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    // reset state
    repeat (3) cyc();
    chk("rst_vram_we", 32'(vram_we), 0);
    chk("rst_vram_addr", 32'(vram_addr), 0);
    chk("rst_vram_data", 32'(vram_data), 0);
    chk("rst_flags", {cpu_full, cpu_ovf, fill_busy, fill_done, fill_err}, 0);
    rst_n = 1'b1;
    cyc();

    // single CPU write, one-cycle latency
    expect_wr(12'h012, 12'hF00);
    cpu_we   = 1'b1;
    cpu_addr = 13'h012;
    cpu_data = 12'hF00;
    chk("cpu_full_idle", 32'(cpu_full), 0);
    cyc();
    cpu_we = 1'b0;
    chk("lat_we", 32'(vram_we), 1);
    chk("lat_addr", 32'(vram_addr), 32'h012);
    chk("lat_data", 32'(vram_data), 32'hF00);
    cyc();
    chk("lat_we_drop", 32'(vram_we), 0);

    // alternation: fill 10,2 3x1 against three CPU writes
    expect_wr(12'h020, 12'h101);
    expect_wr(170, 12'h00F);
    expect_wr(12'h021, 12'h102);
    expect_wr(171, 12'h00F);
    expect_wr(12'h022, 12'h103);
    expect_wr(172, 12'h00F);
    start_fill(7'd10, 6'd2, 7'd3, 6'd1, 12'h00F);
    cyc();
    for (int k = 0; k < 3; k++) begin
      cpu_we   = 1'b1;
      cpu_addr = AW'(12'h020 + k);
      cpu_data = DW'(12'h101 + k);
      cyc();
    end
    cpu_we = 1'b0;
    wait_done("alt_done", 40);
    chk("alt_err", 32'(fill_err), 0);
    chk("alt_busy", 32'(fill_busy), 0);
    chk("alt_drain", 32'(q.size()), 0);

    // clipping: 78,59 5x3 -> 2x1
    expect_wr(4798, 12'h0F0);
    expect_wr(4799, 12'h0F0);
    start_fill(7'd78, 6'd59, 7'd5, 6'd3, 12'h0F0);
    wait_done("clip_done", 40);
    chk("clip_err", 32'(fill_err), 1);
    chk("clip_busy", 32'(fill_busy), 0);
    chk("clip_drain", 32'(q.size()), 0);

    // FIFO full under contention; grant pointer favours FILL here
    for (int i = 0; i < 7; i++) begin
      expect_wr(805 + i, 12'hABC);
      expect_wr(12'h100 + i, DW'(12'h300 + i));
    end
    for (int i = 7; i < 40; i++) expect_wr(805 + i, 12'hABC);
    start_fill(7'd5, 6'd10, 7'd40, 6'd1, 12'hABC);
    cyc();
    for (int k = 0; k < 8; k++) begin
      cpu_we   = 1'b1;
      cpu_addr = AW'(12'h100 + k);
      cpu_data = DW'(12'h300 + k);
      if (k == 6) chk("full_before", 32'(cpu_full), 0);
      if (k == 7) begin
        chk("full_at_8th", 32'(cpu_full), 1);
        chk("ovf_before", 32'(cpu_ovf), 0);
      end
      cyc();
    end
    cpu_we = 1'b0;
    chk("ovf_set", 32'(cpu_ovf), 1);
    wait_done("ff_done", 120);
    chk("ff_err", 32'(fill_err), 0);
    chk("ff_drain", 32'(q.size()), 0);
    chk("ovf_sticky", 32'(cpu_ovf), 1);

    // zero width rejected: done exactly two cycles after start
    start_fill(7'd0, 6'd0, 7'd0, 6'd5, 12'h111);
    chk("rej_done_s1", 32'(fill_done), 0);
    chk("rej_busy_s1", 32'(fill_busy), 1);
    cyc();
    chk("rej_done_s2", 32'(fill_done), 1);
    chk("rej_err", 32'(fill_err), 1);
    cyc();
    chk("rej_done_s3", 32'(fill_done), 0);
    chk("rej_busy_s3", 32'(fill_busy), 0);

    // full screen, no CPU traffic
    for (int i = 0; i < 4800; i++) expect_wr(i, 12'h123);
    begin
      int d0;
      int n;
      int we_cnt;
      int runs;
      bit prev;
      d0 = done_cnt;
      n = 0;
      we_cnt = 0;
      runs = 0;
      prev = 1'b0;
      start_fill(7'd0, 6'd0, 7'd80, 6'd60, 12'h123);
      while (done_cnt == d0 && n < 5000) begin
        cyc();
        if (vram_we) begin
          we_cnt++;
          if (!prev) runs++;
        end
        prev = vram_we;
        n++;
      end
      chk("scr_done", 32'(done_cnt != d0), 1);
      chk("scr_we_cnt", 32'(we_cnt), 4800);
      chk("scr_runs", 32'(runs), 1);
      chk("scr_busy", 32'(fill_busy), 0);
      chk("scr_err", 32'(fill_err), 0);
      chk("scr_drain", 32'(q.size()), 0);
    end

    // x out of range rejected
    start_fill(7'd80, 6'd0, 7'd1, 6'd1, 12'h222);
    wait_done("rejx_done", 10);
    chk("rejx_err", 32'(fill_err), 1);

    // reset mid-fill aborts with no fill_done
    mon_en = 1'b0;
    start_fill(7'd0, 6'd0, 7'd80, 6'd2, 12'h777);
    repeat (10) cyc();
    begin
      int d0;
      d0 = done_cnt;
      rst_n = 1'b0;
      #1;
      chk("mrst_we", 32'(vram_we), 0);
      chk("mrst_addr", 32'(vram_addr), 0);
      chk("mrst_data", 32'(vram_data), 0);
      chk("mrst_flags",
          {cpu_full, cpu_ovf, fill_busy, fill_done, fill_err}, 0);
      repeat (2) cyc();
      rst_n = 1'b1;
      repeat (200) cyc();
      chk("mrst_no_done", 32'(done_cnt), 32'(d0));
      chk("mrst_idle", 32'(fill_busy), 0);
    end
    mon_en = 1'b1;

    // CPU path still works after reset
    expect_wr(12'h055, 12'hABC);
    cpu_we   = 1'b1;
    cpu_addr = 13'h055;
    cpu_data = 12'hABC;
    cyc();
    cpu_we = 1'b0;
    chk("post_we", 32'(vram_we), 1);
    cyc();
    chk("post_drain", 32'(q.size()), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
